// File: rtl/shift_pkg.sv
// Shared definitions for the shift operand stage.
//   - R-type opcode and shift funct codes
//   - shift-function encodings driven onto the shift unit's sf input
//   - entry_t: one decoded, operand-resolved FIFO entry
package shift_pkg;

  localparam logic [5:0] OPCODE_RTYPE = 6'b000000;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  localparam logic [1:0] SF_SLL = 2'b00;
  localparam logic [1:0] SF_SRL = 2'b01;
  localparam logic [1:0] SF_SRA = 2'b11;

  typedef struct packed {
    logic [31:0] a;
    logic [4:0]  sdist;
    logic [1:0]  sf;
    logic [4:0]  dest;
    logic        is_shift;
  } entry_t;

endpackage

// File: rtl/shift_decode.sv
// Combinational shift-instruction decoder.
// Ports:
//   instr       in  32  instruction word
//   is_shift    out 1   R-type SLL/SRL/SRA/SLLV/SRLV/SRAV
//   is_variable out 1   distance comes from rs (SLLV/SRLV/SRAV)
//   sf          out 2   shift function encoding (00 for non-shifts)
module shift_decode
  import shift_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_shift,
  output logic        is_variable,
  output logic [1:0]  sf
);

  // Register fields and shamt are resolved by the parent stage.
  logic w_unused_fields;
  assign w_unused_fields = ^instr[25:6];

  always_comb begin
    is_shift    = 1'b0;
    is_variable = 1'b0;
    sf          = SF_SLL;
    if (instr[31:26] == OPCODE_RTYPE) begin
      case (instr[5:0])
        FUNCT_SLL:  begin is_shift = 1'b1; sf = SF_SLL; end
        FUNCT_SRL:  begin is_shift = 1'b1; sf = SF_SRL; end
        FUNCT_SRA:  begin is_shift = 1'b1; sf = SF_SRA; end
        FUNCT_SLLV: begin is_shift = 1'b1; is_variable = 1'b1; sf = SF_SLL; end
        FUNCT_SRLV: begin is_shift = 1'b1; is_variable = 1'b1; sf = SF_SRL; end
        FUNCT_SRAV: begin is_shift = 1'b1; is_variable = 1'b1; sf = SF_SRA; end
        default:    begin is_shift = 1'b0; end
      endcase
    end
  end

endmodule

// File: rtl/shift_operand_stage.sv
// Operand stage feeding the shift unit: decodes shift instructions,
// resolves rs/rt operands with forwarding, and buffers entries in a FIFO.
// Ports:
//   clk, reset                 clock, async active-high reset
//   in_valid/in_ready          upstream handshake (in_ready = not full)
//   instr, rs_val, rt_val      instruction and register-file operands
//   fwd_en, fwd_reg, fwd_data  forwarding source from a later stage
//   flush                      drop all entries and same-cycle input
//   out_valid/out_ready        downstream handshake on the FIFO head
//   a, sdist, sf               shift unit operands
//   dest, is_shift             writeback side-band
module shift_operand_stage
  import shift_pkg::*;
#(
  parameter int DEPTH = 2
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        fwd_en,
  input  logic [4:0]  fwd_reg,
  input  logic [31:0] fwd_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a,
  output logic [4:0]  sdist,
  output logic [1:0]  sf,
  output logic [4:0]  dest,
  output logic        is_shift
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  // Register 0 always reads zero, so a forward tagged 0 can never match.
  function automatic logic [31:0] sel_operand(input logic [4:0]  field,
                                              input logic [31:0] rf_val,
                                              input logic        f_en,
                                              input logic [4:0]  f_reg,
                                              input logic [31:0] f_data);
    if (field == 5'd0)
      return 32'd0;
    else if (f_en && (f_reg == field))
      return f_data;
    return rf_val;
  endfunction

  logic        w_is_shift;
  logic        w_is_var;
  logic [1:0]  w_sf;
  logic [31:0] w_rs_op;
  logic [31:0] w_rt_op;
  logic        w_unused_rs_hi;
  entry_t      w_entry;
  entry_t      w_head;
  logic        w_push;
  logic        w_pop;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_count;

  shift_decode u_decode (
    .instr       (instr),
    .is_shift    (w_is_shift),
    .is_variable (w_is_var),
    .sf          (w_sf)
  );

  assign w_rs_op = sel_operand(instr[25:21], rs_val, fwd_en, fwd_reg, fwd_data);
  assign w_rt_op = sel_operand(instr[20:16], rt_val, fwd_en, fwd_reg, fwd_data);
  // Only rs_op[4:0] matters as a shift distance.
  assign w_unused_rs_hi = ^w_rs_op[31:5];

  // Capture stage: build the entry; non-shifts keep only dest for ordering.
  always_comb begin
    w_entry      = '0;
    w_entry.dest = instr[15:11];
    if (w_is_shift) begin
      w_entry.a        = w_rt_op;
      w_entry.sdist    = w_is_var ? w_rs_op[4:0] : instr[10:6];
      w_entry.sf       = w_sf;
      w_entry.is_shift = 1'b1;
    end
  end

  assign in_ready  = (r_count != FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // FIFO stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Stale storage after a flush must not leak onto the outputs.
  assign w_head   = out_valid ? r_mem[r_rd_ptr] : '0;
  assign a        = w_head.a;
  assign sdist    = w_head.sdist;
  assign sf       = w_head.sf;
  assign dest     = w_head.dest;
  assign is_shift = w_head.is_shift;

endmodule

// File: tb/tb_shift_operand_stage.sv
module tb_shift_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        fwd_en;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [4:0]  sdist;
  logic [1:0]  sf;
  logic [4:0]  dest;
  logic        is_shift;

  int n_checks = 0;
  int n_fail   = 0;

  logic [44:0] sb [$];
  logic [44:0] exp_e;
  logic [44:0] got_e;

  always #5 clk = ~clk;

  shift_operand_stage #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .fwd_en    (fwd_en),
    .fwd_reg   (fwd_reg),
    .fwd_data  (fwd_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .sdist     (sdist),
    .sf        (sf),
    .dest      (dest),
    .is_shift  (is_shift)
  );

  assign got_e = {a, sdist, sf, dest, is_shift};

  function automatic logic [44:0] mk(input logic [31:0] ea, input logic [4:0] esd,
                                     input logic [1:0] esf, input logic [4:0] ed,
                                     input logic eis);
    return {ea, esd, esf, ed, eis};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [31:0] rs, input logic [31:0] rt);
    in_valid = v;
    instr    = ins;
    rs_val   = rs;
    rt_val   = rt;
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++;
    if (got_e !== 45'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", got_e); end
  endtask

  task automatic test_sll();
    out_ready = 1'b1;
    drive(1'b1, 32'h00051080, 32'h0, 32'h00000001);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sll_in_ready: got %b expected 1", in_ready); end
    sb.push_back(mk(32'h1, 5'd2, 2'b00, 5'd2, 1'b1));
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sll_out_valid: got %b expected 1", out_valid); end
    exp_e = sb.pop_front();
    n_checks++;
    if (got_e !== exp_e) begin n_fail++; $display("FAIL sll_head: got %h expected %h", got_e, exp_e); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sll_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_srav_fwd();
    out_ready = 1'b1;
    // plain SRAV
    drive(1'b1, 32'h00C72007, 32'h00000023, 32'hFFFFFFE0);
    fwd_en = 1'b0;
    sb.push_back(mk(32'hFFFFFFE0, 5'd3, 2'b11, 5'd4, 1'b1));
    tick();
    // rt forwarded, back-to-back with the head popping
    fwd_en = 1'b1; fwd_reg = 5'd7; fwd_data = 32'h00000010;
    sb.push_back(mk(32'h00000010, 5'd3, 2'b11, 5'd4, 1'b1));
    exp_e = sb.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || got_e !== exp_e) begin n_fail++; $display("FAIL srav_plain: got v=%b %h expected v=1 %h", out_valid, got_e, exp_e); end
    tick();
    // rs forwarded
    fwd_reg = 5'd6; fwd_data = 32'h00000025;
    sb.push_back(mk(32'hFFFFFFE0, 5'd5, 2'b11, 5'd4, 1'b1));
    exp_e = sb.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || got_e !== exp_e) begin n_fail++; $display("FAIL srav_fwd_rt: got v=%b %h expected v=1 %h", out_valid, got_e, exp_e); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    fwd_en = 1'b0;
    exp_e = sb.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || got_e !== exp_e) begin n_fail++; $display("FAIL srav_fwd_rs: got v=%b %h expected v=1 %h", out_valid, got_e, exp_e); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL srav_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'h00051080, 32'h0, 32'h00000001);
    sb.push_back(mk(32'h1, 5'd2, 2'b00, 5'd2, 1'b1));
    tick();
    drive(1'b1, 32'h00051082, 32'h0, 32'h80000000);
    sb.push_back(mk(32'h80000000, 5'd2, 2'b01, 5'd2, 1'b1));
    tick();
    // third instruction offered while full
    drive(1'b1, 32'h00051083, 32'h0, 32'hF0000000);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
    exp_e = sb[0];
    n_checks++;
    if (got_e !== exp_e) begin n_fail++; $display("FAIL bp_head_hold0: got %h expected %h", got_e, exp_e); end
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || got_e !== exp_e) begin n_fail++; $display("FAIL bp_head_hold1: got rdy=%b %h expected rdy=0 %h", in_ready, got_e, exp_e); end
    out_ready = 1'b1;
    exp_e = sb.pop_front();
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise: got %b expected 1", in_ready); end
    sb.push_back(mk(32'hF0000000, 5'd2, 2'b11, 5'd2, 1'b1));
    exp_e = sb.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || got_e !== exp_e) begin n_fail++; $display("FAIL bp_second: got v=%b %h expected v=1 %h", out_valid, got_e, exp_e); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    exp_e = sb.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || got_e !== exp_e) begin n_fail++; $display("FAIL bp_third: got v=%b %h expected v=1 %h", out_valid, got_e, exp_e); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin n_fail++; $display("FAIL bp_drained: got v=%b left=%0d expected v=0 left=0", out_valid, sb.size()); end
  endtask

  task automatic test_nonshift();
    out_ready = 1'b1;
    drive(1'b1, 32'h00851020, 32'h11111111, 32'h22222222);
    sb.push_back(mk(32'h0, 5'd0, 2'b00, 5'd2, 1'b0));
    tick();
    // SRLV with rs=0; fwd_reg=0 must not forward
    drive(1'b1, 32'h00051806, 32'hFFFFFFFF, 32'h12345678);
    fwd_en = 1'b1; fwd_reg = 5'd0; fwd_data = 32'hFFFFFFFF;
    sb.push_back(mk(32'h12345678, 5'd0, 2'b01, 5'd3, 1'b1));
    exp_e = sb.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || got_e !== exp_e) begin n_fail++; $display("FAIL ns_add: got v=%b %h expected v=1 %h", out_valid, got_e, exp_e); end
    tick();
    // non-R-type opcode with a shift-like funct
    drive(1'b1, 32'h20051806, 32'h00000004, 32'h12345678);
    fwd_en = 1'b0;
    sb.push_back(mk(32'h0, 5'd0, 2'b00, 5'd3, 1'b0));
    exp_e = sb.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || got_e !== exp_e) begin n_fail++; $display("FAIL ns_srlv_rs0: got v=%b %h expected v=1 %h", out_valid, got_e, exp_e); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    exp_e = sb.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || got_e !== exp_e) begin n_fail++; $display("FAIL ns_opcode: got v=%b %h expected v=1 %h", out_valid, got_e, exp_e); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h00051080, 32'h0, 32'h00000003);
    tick();
    drive(1'b1, 32'h00051082, 32'h0, 32'h00000004);
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL fl_full: got rdy=%b v=%b expected rdy=0 v=1", in_ready, out_valid); end
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h00051083, 32'h0, 32'h00000005);
    tick();
    flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || got_e !== 45'd0) begin n_fail++; $display("FAIL fl_full_flush: got v=%b rdy=%b %h expected v=0 rdy=1 0", out_valid, in_ready, got_e); end
    // flush with one entry and an acceptable push in the same cycle
    drive(1'b1, 32'h00051080, 32'h0, 32'h00000006);
    tick();
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h00051082, 32'h0, 32'h00000007);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || got_e !== 45'd0) begin n_fail++; $display("FAIL fl_push_flush: got v=%b rdy=%b %h expected v=0 rdy=1 0", out_valid, in_ready, got_e); end
    sb.delete();
    // following push appears alone
    drive(1'b1, 32'h00051083, 32'h0, 32'h00000008);
    sb.push_back(mk(32'h8, 5'd2, 2'b11, 5'd2, 1'b1));
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    exp_e = sb.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || got_e !== exp_e) begin n_fail++; $display("FAIL fl_after: got v=%b %h expected v=1 %h", out_valid, got_e, exp_e); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_after_alone: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 32'h00051080, 32'h0, 32'h00000009);
    tick();
    drive(1'b1, 32'h00051082, 32'h0, 32'h0000000A);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rm_pre: got v=%b rdy=%b expected v=1 rdy=0", out_valid, in_ready); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || got_e !== 45'd0) begin n_fail++; $display("FAIL rm_async: got v=%b rdy=%b %h expected v=0 rdy=1 0", out_valid, in_ready, got_e); end
    sb.delete();
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h00051080, 32'h0, 32'h00000001);
    sb.push_back(mk(32'h1, 5'd2, 2'b00, 5'd2, 1'b1));
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    exp_e = sb.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || got_e !== exp_e) begin n_fail++; $display("FAIL rm_fresh: got v=%b %h expected v=1 %h", out_valid, got_e, exp_e); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_fresh_drained: got %b expected 0", out_valid); end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    instr     = '0;
    rs_val    = '0;
    rt_val    = '0;
    fwd_en    = 1'b0;
    fwd_reg   = '0;
    fwd_data  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_sll();
    test_srav_fwd();
    test_backpressure();
    test_nonshift();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
